// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the MU0 memory between core port C and UART loader port D.
// Ports: clk, rst; cpu_* core port; dbg_* loader port with dbg_lock/dbg_lock_gnt; mem_* memory side.
// Round-robin on contention; dbg_lock gives D exclusive ownership and stalls the core.
// Build option ARB_STATS_EN adds stats_clr (in) and cpu_wait_cnt[15:0] (out).
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_rnw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  input  logic              dbg_lock,
  output logic              dbg_lock_gnt,
  output logic              mem_en,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       cpu_wait_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);
  localparam logic       OWN_C  = 1'b0;
  localparam logic       OWN_D  = 1'b1;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic              rnw_q, rnw_d;
  logic              lock_q, lock_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              cack_q, cack_d;
  logic              dack_q, dack_d;
  logic              c_elig, d_elig;
  logic              grant_c, grant_d;
  logic              done;

  // A lock request seen in IDLE already keeps the core off the bus,
  // so no core access can slip in on the acceptance cycle.
  always_comb begin
    c_elig  = cpu_req && !cack_q && !lock_q && !dbg_lock;
    d_elig  = dbg_req && !dack_q;
    grant_c = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        c_elig && d_elig: begin
          grant_d = (last_q == OWN_C);
          grant_c = !grant_d;
        end
        c_elig && !d_elig: grant_c = 1'b1;
        !c_elig && d_elig: grant_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    done    = 1'b0;
    // Lock is accepted only between accesses; release is immediate.
    lock_d  = dbg_lock && (lock_q || state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (grant_c || grant_d) begin
          state_d = ISSUE;
          own_d   = grant_d;
          last_d  = grant_d;
          rnw_d   = grant_d ? dbg_rnw : cpu_rnw;
          addr_d  = grant_d ? dbg_addr : cpu_addr;
          wdata_d = grant_d ? dbg_wdata : cpu_wdata;
        end
      end
      ISSUE: begin
        if (rnw_q) begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          done    = 1'b1;
          if (own_q == OWN_D) begin
            drd_d = mem_rdata;
          end else begin
            crd_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    cack_d = done && (own_q == OWN_C);
    dack_d = done && (own_q == OWN_D);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWN_C;
      own_q   <= OWN_C;
      rnw_q   <= 1'b0;
      lock_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      drd_q   <= '0;
      cnt_q   <= '0;
      cack_q  <= 1'b0;
      dack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      rnw_q   <= rnw_d;
      lock_q  <= lock_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
      cnt_q   <= cnt_d;
      cack_q  <= cack_d;
      dack_q  <= dack_d;
    end
  end

  assign mem_en       = (state_q == ISSUE);
  assign mem_rnw      = rnw_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_ack      = cack_q;
  assign dbg_ack      = dack_q;
  assign cpu_rdata    = crd_q;
  assign dbg_rdata    = drd_q;
  assign dbg_lock_gnt = lock_q;
  assign cpu_stall    = lock_q;

`ifdef ARB_STATS_EN
  logic [15:0] wcnt_q;
  logic        c_busy;
  logic        c_wait;

  // Core waiting: requesting, not being granted, not owning the bus
  // and not on its completion cycle.
  assign c_busy = (state_q != IDLE) && (own_q == OWN_C);
  assign c_wait = cpu_req && !grant_c && !c_busy && !cack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if (stats_clr) begin
      wcnt_q <= '0;
    end else if (c_wait && wcnt_q != 16'hFFFF) begin
      wcnt_q <= wcnt_q + 16'd1;
    end
  end

  assign cpu_wait_cnt = wcnt_q;
`endif

endmodule
